// File: rtl/generic_fifo_pkg.sv
// Shared types and helpers for the generic single-clock FIFO.
// Holds the ceil-log2 helper used to size the storage index and the
// registered status-flag bundle.
package generic_fifo_pkg;

    // Number of address bits needed to index 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Registered status flags. They are kept together because all four
    // are derived from the same next-state occupancy.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    // Flag values for an empty FIFO.
    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/generic_fifo_ptr.sv
// Wrapping FIFO pointer: counts 0 .. NUM_OF_ENTRIES-1 and returns to 0.
// The wrap is explicit, so depths that are not a power of two work.
// clr_i has priority over inc_i.
module generic_fifo_ptr #(
    parameter int PTR_WIDTH      = 8,
    parameter int NUM_OF_ENTRIES = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);

    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(NUM_OF_ENTRIES - 1);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    // Next pointer: clear, hold, step, or wrap from the last entry to 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_WIDTH'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/generic_1clk_fifo_env.sv
// Single-clock parametrised FIFO with flop storage and per-bit write mask.
// Provides registered full/empty/almost flags and occupancy, a synchronous
// flush, and sticky overflow/underflow flags.
// Build option: define GENERIC_1CLK_FIFO_FWFT_EN for a first-word-fall-through
// read port; the default is a registered read port with 1-cycle latency.
module generic_1clk_fifo_env
    import generic_fifo_pkg::*;
#(
    parameter int PTR_WIDTH      = 8,
    parameter int NUM_OF_ENTRIES = 256,
    parameter int DAT_WIDTH      = 32,
    parameter int AFULL_LVL      = NUM_OF_ENTRIES - 2,
    parameter int AEMPTY_LVL     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 wr_op,
    input  logic [DAT_WIDTH-1:0] wr_data,
    input  logic [DAT_WIDTH-1:0] wr_mask,
    input  logic                 rd_op,
    output logic [DAT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   entry_used,
    output logic                 wr_full_err,
    output logic                 rd_empty_err
);

    localparam int                 IDX_W      = clog2(NUM_OF_ENTRIES);
    localparam logic [PTR_WIDTH:0] CNT_MAX    = (PTR_WIDTH + 1)'(NUM_OF_ENTRIES);
    localparam logic [PTR_WIDTH:0] AFULL_CNT  = (PTR_WIDTH + 1)'(AFULL_LVL);
    localparam logic [PTR_WIDTH:0] AEMPTY_CNT = (PTR_WIDTH + 1)'(AEMPTY_LVL);

    logic [DAT_WIDTH-1:0] mem_q [NUM_OF_ENTRIES];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   count_q, count_d;
    fifo_flags_t          flags_q, flags_d;
    logic                 wr_err_q, wr_err_d;
    logic                 rd_err_q, rd_err_d;
    logic                 wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO rejects a write
    // even when a read drains an entry in the same cycle (and vice versa).
    assign wr_acc = wr_op & ~flags_q.full  & ~flush;
    assign rd_acc = rd_op & ~flags_q.empty & ~flush;

    generic_fifo_ptr #(
        .PTR_WIDTH      (PTR_WIDTH),
        .NUM_OF_ENTRIES (NUM_OF_ENTRIES)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (flush),
        .inc_i   (wr_acc),
        .ptr_o   (wr_ptr)
    );

    generic_fifo_ptr #(
        .PTR_WIDTH      (PTR_WIDTH),
        .NUM_OF_ENTRIES (NUM_OF_ENTRIES)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (flush),
        .inc_i   (rd_acc),
        .ptr_o   (rd_ptr)
    );

    // Masked write into storage: bits with wr_mask=0 keep their old value.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; contents are don't-care until written and resetting every entry only costs routing.
        if (wr_acc) begin
            mem_q[wr_ptr[IDX_W-1:0]] <= (mem_q[wr_ptr[IDX_W-1:0]] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Next occupancy, flags and sticky errors; flush overrides everything.
    always_comb begin
        count_d  = count_q;
        wr_err_d = wr_err_q;
        rd_err_d = rd_err_q;
        if (flush) begin
            count_d  = '0;
            wr_err_d = 1'b0;
            rd_err_d = 1'b0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (PTR_WIDTH + 1)'(1);
                2'b01:   count_d = count_q - (PTR_WIDTH + 1)'(1);
                default: count_d = count_q;
            endcase
            wr_err_d = wr_err_q | (wr_op & flags_q.full);
            rd_err_d = rd_err_q | (rd_op & flags_q.empty);
        end
        flags_d.full   = (count_d == CNT_MAX);
        flags_d.empty  = (count_d == '0);
        flags_d.afull  = (count_d >= AFULL_CNT);
        flags_d.aempty = (count_d <= AEMPTY_CNT);
    end

    // Occupancy, flag and error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            flags_q  <= FLAGS_RESET;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            flags_q  <= flags_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

`ifdef GENERIC_1CLK_FIFO_FWFT_EN
    // Head entry is always on the read port; rd_op just pops it.
    assign rd_data  = mem_q[rd_ptr[IDX_W-1:0]];
    assign rd_valid = ~flags_q.empty;
`else
    logic [DAT_WIDTH-1:0] rd_data_q;
    logic                 rd_valid_q;

    // Registered read port: loads on an accepted pop, pulses rd_valid once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_q[rd_ptr[IDX_W-1:0]];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.afull;
    assign almost_empty = flags_q.aempty;
    assign entry_used   = count_q;
    assign wr_full_err  = wr_err_q;
    assign rd_empty_err = rd_err_q;

endmodule
